// File: rtl/writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_pkg
// Brief   : Shared constants and the buffer entry type for writeback_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic        live;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : writeback_arbiter_if
// Brief   : Result ports A/B and register-file write bus of writeback_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface writeback_arbiter_if
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) ();

  logic                     a_valid;
  logic [4:0]               a_waddr;
  logic [31:0]              a_wdata;
  logic                     b_valid;
  logic                     b_ready;
  logic [4:0]               b_waddr;
  logic [31:0]              b_wdata;
  logic                     wen;
  logic [4:0]               waddr;
  logic [31:0]              wdata;
  logic [31:0]              busy;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output a_valid, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
    input  b_ready, wen, waddr, wdata, busy, count
  );

  modport slave (
    input  a_valid, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
    output b_ready, wen, waddr, wdata, busy, count
  );

endinterface
`default_nettype wire

// File: rtl/writeback_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_fifo
// Brief   : Circular result buffer with per-address squash and busy scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_i,
  input  wb_entry_t                enq_entry_i,
  input  logic                     deq_i,
  input  logic                     squash_i,
  input  logic [4:0]               squash_addr_i,
  output wb_entry_t                head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [31:0]              busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       entries_q [DEPTH];
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  assign count_d = count_q + CW'(enq_i) - CW'(deq_i);

  // Unoccupied slots always hold live=0, so the squash and busy scans need no occupancy mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_i && entries_q[i].live && (entries_q[i].waddr == squash_addr_i)) begin
          entries_q[i].live <= 1'b0;
        end
      end
      if (deq_i) begin
        entries_q[head_q].live <= 1'b0;
        head_q                 <= head_q + PW'(1);
      end
      if (enq_i) begin
        entries_q[tail_q] <= enq_entry_i;
        tail_q            <= tail_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].live) begin
        busy_o[entries_q[i].waddr] = 1'b1;
      end
    end
    busy_o[0] = 1'b0;
  end

  assign head_o  = entries_q[head_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : writeback_arbiter
// Brief   : Merges single-cycle (A) and buffered long-latency (B) writebacks.
// Revision: 1.0 - initial release
// ============================================================================
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  writeback_arbiter_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            w_a_claim;
  logic            w_b_fire;
  logic            w_enq;
  logic            w_has_head;
  logic            w_deq;
  logic            w_deq_write;
  wb_entry_t       w_enq_entry;
  wb_entry_t       w_head;
  logic [CW-1:0]   w_count;
  logic [31:0]     w_busy;

  logic            wen_q,   wen_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;

  assign w_a_claim = bus.a_valid && (bus.a_waddr != 5'd0);
  assign bus.b_ready = !rst && (w_count < CW'(DEPTH));
  assign w_b_fire  = bus.b_valid && bus.b_ready;
  assign w_enq     = w_b_fire && (bus.b_waddr != 5'd0);

  // A same-cycle A write to the same register is younger, so the B entry is born dead.
  assign w_enq_entry.live  = !(w_a_claim && (bus.a_waddr == bus.b_waddr));
  assign w_enq_entry.waddr = bus.b_waddr;
  assign w_enq_entry.wdata = bus.b_wdata;

  assign w_has_head  = (w_count != '0);
  assign w_deq       = w_has_head && (!w_head.live || !w_a_claim);
  assign w_deq_write = w_deq && w_head.live;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .enq_i         (w_enq),
    .enq_entry_i   (w_enq_entry),
    .deq_i         (w_deq),
    .squash_i      (w_a_claim),
    .squash_addr_i (bus.a_waddr),
    .head_o        (w_head),
    .count_o       (w_count),
    .busy_o        (w_busy)
  );

  always_comb begin
    wen_d   = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    if (w_a_claim) begin
      wen_d   = 1'b1;
      waddr_d = bus.a_waddr;
      wdata_d = bus.a_wdata;
    end else if (w_deq_write) begin
      wen_d   = 1'b1;
      waddr_d = w_head.waddr;
      wdata_d = w_head.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.wen   = wen_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign bus.busy  = w_busy;
  assign bus.count = w_count;

endmodule
`default_nettype wire
